// File: rtl/uart_mmio.sv
// ---------------------------------------------------------------------------
// uart_mmio : memory-mapped 8N1 UART with 16x oversampling.
//
// Registers (word addresses, addr[1:0] ignored):
//   BASE+0  TXD  write-only.  A write while idle starts a frame. Reads return 0.
//   BASE+4  RXD  read-only.   {24'b0, rx_data}. A read clears rx_valid.
//   BASE+8  CON  {25'b0, ovr, ferr, tx_busy, rx_valid, tx_done, rx_ie, tx_ie}.
//                A write sets tx_ie/rx_ie. A read clears tx_done, ferr and ovr.
//
// Ports:
//   clk       system clock, all state on posedge
//   reset     asynchronous active-low reset
//   addr      MEM-stage byte address
//   mem_rd    read strobe (read side effects occur on the posedge)
//   mem_wr    write strobe, sampled on posedge
//   wdata     write data, only [7:0] used
//   rdata     read data, combinational
//   uart_rxd  asynchronous serial input, idle high
//   uart_txd  serial output, idle high
//   irq       level interrupt, registered
//
// TX FSM states
//   TX_IDLE  | line idle high, waiting for a TXD write
//   TX_START | start bit (low) for 16 ticks
//   TX_DATA  | 8 data bits LSB first, 16 ticks each
//   TX_STOP  | stop bit (high) for 16 ticks, then tx_done
// RX FSM states
//   RX_IDLE  | waiting for a synchronised falling edge
//   RX_START | confirm start bit at its centre (tick 8)
//   RX_DATA  | sample 8 bit centres, LSB first
//   RX_STOP  | sample stop bit centre, deliver byte or flag ferr
//   RX_BRK   | framing error seen, wait for line to go high
// ---------------------------------------------------------------------------
module uart_mmio #(
    parameter int          OVS_DIV   = 326,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);

    localparam int              DW       = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(OVS_DIV - 1);
    localparam logic [29:0]     TXD_W    = BASE_ADDR[31:2];
    localparam logic [29:0]     RXD_W    = TXD_W + 30'd1;
    localparam logic [29:0]     CON_W    = TXD_W + 30'd2;

    // ---------------------------------------------------------------- ticks
    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + 1'b1;
    end

    // -------------------------------------------------------- address decode
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign sel_txd = (addr[31:2] == TXD_W);
    assign sel_rxd = (addr[31:2] == RXD_W);
    assign sel_con = (addr[31:2] == CON_W);
    assign wr_txd  = mem_wr & sel_txd;
    assign wr_con  = mem_wr & sel_con;
    assign rd_rxd  = mem_rd & sel_rxd;
    assign rd_con  = mem_rd & sel_con;

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], addr[1:0]};

    // ---------------------------------------------------------------- TX FSM
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t  tx_state_q;
    logic [7:0] tx_sh_q;
    logic [3:0] tx_tmr_q;
    logic [2:0] tx_bit_q;
    logic       txd_q;
    logic       tx_bit_end;
    logic       tx_end;
    logic       tx_busy;

    assign tx_bit_end = tick && (tx_tmr_q == 4'd0);
    assign tx_end     = (tx_state_q == TX_STOP) && tx_bit_end;
    assign tx_busy    = (tx_state_q != TX_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            // 4-bit down-counter: wrapping 0 -> 15 reloads the next bit period
            if (tick && tx_state_q != TX_IDLE)
                tx_tmr_q <= tx_tmr_q - 4'd1;
            case (tx_state_q)
                TX_IDLE: begin
                    if (wr_txd) begin
                        tx_sh_q    <= wdata[7:0];
                        tx_tmr_q   <= 4'd15;
                        txd_q      <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_bit_q   <= '0;
                        txd_q      <= tx_sh_q[0];
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_sh_q  <= tx_sh_q >> 1;
                            txd_q    <= tx_sh_q[1];
                            tx_bit_q <= tx_bit_q + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end)
                        tx_state_q <= TX_IDLE;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign uart_txd = txd_q;

    // ---------------------------------------------------------------- RX FSM
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;

    rx_state_t  rx_state_q;
    logic       rx_s1_q, rx_s2_q, rx_s3_q;
    logic [7:0] rx_sh_q;
    logic [3:0] rx_tmr_q;
    logic [2:0] rx_bit_q;
    logic       rx_smp;
    logic       rx_ok;
    logic       rx_bad;

    assign rx_smp = tick && (rx_tmr_q == 4'd0);
    assign rx_ok  = (rx_state_q == RX_STOP) && rx_smp &&  rx_s2_q;
    assign rx_bad = (rx_state_q == RX_STOP) && rx_smp && !rx_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_sh_q    <= '0;
            rx_tmr_q   <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_s1_q <= uart_rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            if (tick && (rx_state_q == RX_START || rx_state_q == RX_DATA ||
                         rx_state_q == RX_STOP))
                rx_tmr_q <= rx_tmr_q - 4'd1;
            case (rx_state_q)
                RX_IDLE: begin
                    // 8 ticks to the start-bit centre, then 16 per bit after wrap
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_tmr_q   <= 4'd7;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_smp) begin
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_smp) begin
                        rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_smp)
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_BRK;
                end
                RX_BRK: begin
                    if (rx_s2_q)
                        rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ flags and irq
    logic [7:0] rx_data_q;
    logic tx_ie_q, rx_ie_q, tx_done_q, rx_valid_q, ferr_q, ovr_q, irq_q;
    logic tx_ie_d, rx_ie_d, tx_done_d, rx_valid_d, ferr_d, ovr_d;

    // Clears are applied first so that a same-cycle set wins.
    always_comb begin
        tx_ie_d    = wr_con ? wdata[0] : tx_ie_q;
        rx_ie_d    = wr_con ? wdata[1] : rx_ie_q;
        tx_done_d  = tx_done_q;
        rx_valid_d = rx_valid_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        if (rd_con) begin
            tx_done_d = 1'b0;
            ferr_d    = 1'b0;
            ovr_d     = 1'b0;
        end
        if (rd_rxd) rx_valid_d = 1'b0;
        if (tx_end) tx_done_d  = 1'b1;
        if (rx_ok)  rx_valid_d = 1'b1;
        if (rx_bad) ferr_d     = 1'b1;
        if (rx_ok && rx_valid_q && !rd_rxd) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q  <= '0;
            tx_ie_q    <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (rx_ok) rx_data_q <= rx_sh_q;
            tx_ie_q    <= tx_ie_d;
            rx_ie_q    <= rx_ie_d;
            tx_done_q  <= tx_done_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            // built from next-state flags so irq drops together with the flag
            irq_q      <= (tx_ie_d & tx_done_d) | (rx_ie_d & rx_valid_d);
        end
    end

    assign irq = irq_q;

    // ------------------------------------------------------------- read mux
    always_comb begin
        rdata = '0;
        if (mem_rd) begin
            if (sel_rxd)
                rdata = {24'b0, rx_data_q};
            else if (sel_con)
                rdata = {25'b0, ovr_q, ferr_q, tx_busy, rx_valid_q,
                         tx_done_q, rx_ie_q, tx_ie_q};
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
module tb_uart_mmio;

    localparam int          OVS   = 4;
    localparam int          BITC  = 16 * OVS;
    localparam logic [31:0] A_TXD = 32'h40000018;
    localparam logic [31:0] A_RXD = 32'h4000001C;
    localparam logic [31:0] A_CON = 32'h40000020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;
    wire  [31:0] rdata;
    wire         uart_txd;
    wire         irq;
    wire         uart_rxd = loop_en ? uart_txd : rxd_drv;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: UART state as seen from software
    logic       m_tx_ie, m_rx_ie, m_tx_done, m_rx_valid, m_ferr, m_ovr;
    logic [7:0] m_rx_data;

    uart_mmio #(.OVS_DIV(OVS), .BASE_ADDR(A_TXD)) dut (
        .clk(clk), .reset(reset), .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wdata(wdata), .rdata(rdata), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_con();
        return {25'b0, m_ovr, m_ferr, 1'b0, m_rx_valid, m_tx_done, m_rx_ie, m_tx_ie};
    endfunction

    function automatic logic m_irq();
        return (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_valid);
    endfunction

    task automatic model_reset();
        m_tx_ie = 0; m_rx_ie = 0; m_tx_done = 0; m_rx_valid = 0;
        m_ferr = 0; m_ovr = 0; m_rx_data = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (m_rx_valid) m_ovr = 1;
            m_rx_valid = 1;
            m_rx_data  = b;
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; mem_wr = 1'b1;
        @(negedge clk);
        mem_wr = 1'b0; addr = '0; wdata = '0;
        if (a == A_CON) begin
            m_tx_ie = d[0];
            m_rx_ie = d[1];
        end
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; mem_rd = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        mem_rd = 1'b0; addr = '0;
        if (a == A_CON) begin
            m_tx_done = 0; m_ferr = 0; m_ovr = 0;
        end
        if (a == A_RXD) m_rx_valid = 0;
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            rxd_drv = fr[k];
            repeat (BITC) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (BITC) @(negedge clk);
        model_frame(b, stop_bit);
    endtask

    // samples each bit of the next frame on uart_txd near its centre
    task automatic capture_tx(output logic [9:0] bits, output logic seen);
        seen = 1'b0;
        bits = '1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) seen = 1'b1;
        end
        if (seen) begin
            repeat (BITC / 2) @(negedge clk);
            bits[0] = uart_txd;
            for (int k = 1; k < 10; k++) begin
                repeat (BITC) @(negedge clk);
                bits[k] = uart_txd;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        logic [31:0] v;
        model_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (uart_txd !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: txd=%b irq=%b expected txd=1 irq=0", uart_txd, irq);
        end
        reset = 1'b1;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || irq !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_lines: %0d bad cycles, expected 0", bad);
        end
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_con: got %h expected 00000000", v); end
        cpu_read(A_RXD, v);
        n_cmp++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_rxd: got %h expected 00000000", v); end
    endtask

    task automatic test_tx(input logic [7:0] b, input logic ie);
        logic [9:0]  bits, expb;
        logic        seen;
        logic [31:0] v, busy_v, exp;
        int          lows;
        cpu_write(A_CON, {31'b0, ie});
        expb = {1'b1, b, 1'b0};
        fork
            capture_tx(bits, seen);
            begin
                cpu_write(A_TXD, {24'b0, b});
                repeat (150) @(negedge clk);
                cpu_read(A_CON, busy_v);
                cpu_write(A_TXD, {24'b0, ~b});
            end
        join
        n_cmp++;
        if (busy_v[4] !== 1'b1) begin
            n_fail++; $display("FAIL tx_busy: got %b expected 1", busy_v[4]);
        end
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("FAIL tx_start_timeout: no start bit within 300 cycles");
        end else begin
            for (int k = 0; k < 10; k++) begin
                n_cmp++;
                if (bits[k] !== expb[k]) begin
                    n_fail++;
                    $display("FAIL tx_bit%0d (byte %h): got %b expected %b", k, b, bits[k], expb[k]);
                end
            end
        end
        repeat (40) @(negedge clk);
        m_tx_done = 1;
        n_cmp++;
        if (irq !== m_irq()) begin n_fail++; $display("FAIL tx_irq: got %b expected %b", irq, m_irq()); end
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL tx_con: got %h expected %h", v, exp); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (irq !== m_irq()) begin n_fail++; $display("FAIL tx_irq_clear: got %b expected %b", irq, m_irq()); end
        lows = 0;
        repeat (700) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != 0) begin n_fail++; $display("FAIL tx_busy_write_ignored: %0d low cycles, expected 0", lows); end
    endtask

    task automatic test_rx_basic();
        logic [31:0] v, exp;
        cpu_write(A_CON, 32'h2);
        uart_send(8'hA5, 1'b1);
        n_cmp++;
        if (irq !== m_irq()) begin n_fail++; $display("FAIL rx_irq: got %b expected %b", irq, m_irq()); end
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL rx_con_valid: got %h expected %h", v, exp); end
        exp = {24'b0, m_rx_data};
        cpu_read(A_RXD, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL rx_data: got %h expected %h", v, exp); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (irq !== m_irq()) begin n_fail++; $display("FAIL rx_irq_clear: got %b expected %b", irq, m_irq()); end
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL rx_con_cleared: got %h expected %h", v, exp); end
    endtask

    task automatic test_rx_random();
        logic [31:0] v, exp;
        logic [7:0]  b;
        cpu_write(A_CON, 32'h0);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            uart_send(b, 1'b1);
            exp = {24'b0, m_rx_data};
            cpu_read(A_RXD, v);
            n_cmp++;
            if (v !== exp) begin n_fail++; $display("FAIL rx_rand%0d: got %h expected %h", i, v, exp); end
            exp = m_con();
            cpu_read(A_CON, v);
            n_cmp++;
            if (v !== exp) begin n_fail++; $display("FAIL rx_rand_con%0d: got %h expected %h", i, v, exp); end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] v, exp;
        uart_send(8'h12, 1'b1);
        uart_send(8'h34, 1'b1);
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL ovr_con: got %h expected %h", v, exp); end
        exp = {24'b0, m_rx_data};
        cpu_read(A_RXD, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL ovr_data: got %h expected %h", v, exp); end
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL ovr_cleared: got %h expected %h", v, exp); end
    endtask

    task automatic test_glitch();
        logic [31:0] v, exp;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (300) @(negedge clk);
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL glitch_con: got %h expected %h", v, exp); end
    endtask

    task automatic test_frame_err();
        logic [31:0] v, exp;
        logic [7:0]  b, c;
        b = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 255));
        uart_send(b, 1'b1);
        uart_send(c, 1'b0);
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL ferr_con: got %h expected %h", v, exp); end
        exp = {24'b0, m_rx_data};
        cpu_read(A_RXD, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected %h", v, exp); end
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL ferr_cleared: got %h expected %h", v, exp); end
    endtask

    task automatic test_loopback(input logic [7:0] b);
        logic [31:0] v, exp;
        loop_en = 1'b1;
        cpu_write(A_CON, 32'h3);
        cpu_write(A_TXD, {24'b0, b});
        repeat (11 * BITC) @(negedge clk);
        m_tx_done = 1;
        model_frame(b, 1'b1);
        n_cmp++;
        if (irq !== m_irq()) begin n_fail++; $display("FAIL loop_irq: got %b expected %b", irq, m_irq()); end
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL loop_con: got %h expected %h", v, exp); end
        exp = {24'b0, m_rx_data};
        cpu_read(A_RXD, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL loop_data: got %h expected %h", v, exp); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v, exp;
        int lows;
        cpu_write(A_CON, 32'h3);
        cpu_write(A_TXD, 32'h00);
        repeat (200) @(negedge clk);
        n_cmp++;
        if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL mid_frame_low: got %b expected 0", uart_txd); end
        #2 reset = 1'b0;
        addr = A_CON; mem_rd = 1'b1;
        #1;
        n_cmp++;
        if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL async_reset_txd: got %b expected 1", uart_txd); end
        n_cmp++;
        if (rdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_rdata_irq: rdata=%h irq=%b expected 0/0", rdata, irq);
        end
        mem_rd = 1'b0; addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        lows = 0;
        repeat (700) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != 0) begin n_fail++; $display("FAIL post_reset_idle: %0d low cycles, expected 0", lows); end
        exp = m_con();
        cpu_read(A_CON, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL post_reset_con: got %h expected %h", v, exp); end
        exp = {24'b0, m_rx_data};
        cpu_read(A_RXD, v);
        n_cmp++;
        if (v !== exp) begin n_fail++; $display("FAIL post_reset_rxd: got %h expected %h", v, exp); end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx(8'h55, 1'b1);
        test_tx(8'($urandom_range(0, 255)), 1'b0);
        test_rx_basic();
        test_rx_random();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_loopback(8'h3C);
        test_loopback(8'($urandom_range(0, 255)));
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
